spi_request_scheduler: RTL

Sequences the SPI sin-index request block. It issues periodic one-cycle start_transfer pulses and accepts each completed 16-bit read (sin_index, uart_id). Each sin_index is dispatched to a per-UART output register with an update strobe. If the SPI request block fails to return data within a bounded time, the scheduler pulses that block's reset and counts the error. Sits between the SPI request block and the per-channel UART/modulation logic.

---
 rtl/spi_request_scheduler.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/spi_request_scheduler.sv
// Periodic request sequencer for the SPI sin-index reader: issues start pulses,
// dispatches returned samples to per-UART slots, and recovers the reader on timeout.
module spi_request_scheduler #(
    parameter int PERIOD_CYCLES  = 2500,
    parameter int TIMEOUT_CYCLES = 200,
    parameter int RESET_CYCLES   = 4,
    parameter int NUM_UARTS      = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    output logic                    start_transfer,
    output logic                    spi_reset,
    input  logic                    data_valid,
    input  logic [11:0]             sin_index,
    input  logic [3:0]              uart_id,
    output logic [12*NUM_UARTS-1:0] ch_sin_index,
    output logic [NUM_UARTS-1:0]    ch_update,
    output logic                    err_timeout,
    output logic                    err_bad_id,
    output logic                    missed_tick,
    output logic [7:0]              timeout_count,
    output logic [7:0]              bad_id_count,
    output logic                    busy
);

    localparam int PW = $clog2(PERIOD_CYCLES);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW = $clog2(RESET_CYCLES + 1);

    localparam logic [PW-1:0] PERIOD_LAST  = PW'(PERIOD_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RESET_LAST   = RW'(RESET_CYCLES - 1);
    localparam logic [3:0]    NUM_ID       = 4'(NUM_UARTS);

    typedef enum logic [1:0] {
        IDLE,
        REQUEST,
        WAIT_DATA,
        RECOVER
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [PW-1:0]   period_cnt;
    logic [TW-1:0]   timeout_cnt;
    logic [RW-1:0]   recover_cnt;
    logic            dv_prev;
    logic            tick;
    logic            dv_rise;
    logic            id_ok;
    logic            timeout_hit;
    logic            accept;

    assign tick        = (period_cnt == PERIOD_LAST);
    assign dv_rise     = data_valid & ~dv_prev;
    assign id_ok       = (uart_id < NUM_ID);
    assign timeout_hit = (timeout_cnt == TIMEOUT_LAST);
    assign accept      = (state == WAIT_DATA) && dv_rise;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A data edge in the final wait cycle takes priority over the timeout.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (tick && enable) next_state = REQUEST;
            REQUEST:   next_state = WAIT_DATA;
            WAIT_DATA: begin
                if (dv_rise) begin
                    next_state = IDLE;
                end else if (timeout_hit) begin
                    next_state = RECOVER;
                end
            end
            RECOVER:   if (recover_cnt == RESET_LAST) next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period_cnt  <= '0;
            timeout_cnt <= '0;
            recover_cnt <= '0;
            dv_prev     <= 1'b0;
        end else begin
            dv_prev <= data_valid;

            if (!enable || tick) begin
                period_cnt <= '0;
            end else begin
                period_cnt <= period_cnt + 1'b1;
            end

            if (state == REQUEST) begin
                timeout_cnt <= '0;
            end else if (state == WAIT_DATA) begin
                timeout_cnt <= timeout_cnt + 1'b1;
            end

            if (state == RECOVER) begin
                recover_cnt <= recover_cnt + 1'b1;
            end else begin
                recover_cnt <= '0;
            end
        end
    end

    // Control outputs are registered from next_state so they align with the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_transfer <= 1'b0;
            spi_reset      <= 1'b0;
            busy           <= 1'b0;
            err_timeout    <= 1'b0;
            err_bad_id     <= 1'b0;
            missed_tick    <= 1'b0;
            timeout_count  <= '0;
            bad_id_count   <= '0;
            ch_update      <= '0;
            ch_sin_index   <= '0;
        end else begin
            start_transfer <= (next_state == REQUEST);
            spi_reset      <= (next_state == RECOVER);
            busy           <= (next_state != IDLE);
            err_timeout    <= (state == WAIT_DATA) && !dv_rise && timeout_hit;
            err_bad_id     <= accept && !id_ok;
            missed_tick    <= tick && (state != IDLE);

            if ((state == WAIT_DATA) && !dv_rise && timeout_hit && (timeout_count != 8'hFF)) begin
                timeout_count <= timeout_count + 8'd1;
            end
            if (accept && !id_ok && (bad_id_count != 8'hFF)) begin
                bad_id_count <= bad_id_count + 8'd1;
            end

            ch_update <= '0;
            for (int k = 0; k < NUM_UARTS; k++) begin
                if (accept && (uart_id == 4'(k))) begin
                    ch_update[k]            <= 1'b1;
                    ch_sin_index[k*12 +: 12] <= sin_index;
                end
            end
        end
    end

endmodule
